// File: rtl/img_proc_pkg.sv
// img_proc_pkg: shared image-pipeline geometry defaults, pixel and 3x3 window types
package img_proc_pkg;
    localparam int IMG_HDISP_DEF = 640;
    localparam int IMG_VDISP_DEF = 480;
    localparam int PIX_WIDTH = 8;
    typedef logic [PIX_WIDTH-1:0] pixel_t;
    typedef struct packed {
        pixel_t p11, p12, p13;
        pixel_t p21, p22, p23;
        pixel_t p31, p32, p33;
    } window_t;
endpackage

// File: rtl/matrix_3x3_generator_line_shift_ram.sv
// matrix_3x3_generator_line_shift_ram: two cascaded line delays with registered taps
module matrix_3x3_generator_line_shift_ram
    import img_proc_pkg::*;
#(
    parameter int RAM_Length = IMG_HDISP_DEF,
    parameter int DATA_WIDTH = PIX_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  clken,
    input  logic [DATA_WIDTH-1:0] shiftin,
    output logic [DATA_WIDTH-1:0] taps0x,
    output logic [DATA_WIDTH-1:0] taps1x
);
    localparam int AW = (RAM_Length > 1) ? $clog2(RAM_Length) : 1;
    logic [DATA_WIDTH-1:0] line0 [RAM_Length];
    logic [DATA_WIDTH-1:0] line1 [RAM_Length];
    logic [AW-1:0]         ptr;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clken)
            ptr <= (ptr == AW'(RAM_Length - 1)) ? '0 : ptr + AW'(1);
    end
    always_ff @(posedge clock) begin
        if (clken) begin
            taps0x     <= line0[ptr];
            taps1x     <= line1[ptr];
            line0[ptr] <= shiftin;
            line1[ptr] <= line0[ptr];
        end
    end
endmodule

// File: rtl/matrix_3x3_generator.sv
// matrix_3x3_generator: raster stream to 3x3 neighbourhood window with border masking
module matrix_3x3_generator
    import img_proc_pkg::*;
#(
    parameter int IMG_HDISP  = IMG_HDISP_DEF,
    parameter int IMG_VDISP  = IMG_VDISP_DEF,
    parameter int DATA_WIDTH = PIX_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  per_frame_vsync,
    input  logic                  per_frame_href,
    input  logic                  per_frame_clken,
    input  logic [DATA_WIDTH-1:0] per_img_Y,
    output logic                  matrix_frame_vsync,
    output logic                  matrix_frame_href,
    output logic                  matrix_frame_clken,
    output logic [DATA_WIDTH-1:0] matrix_p11,
    output logic [DATA_WIDTH-1:0] matrix_p12,
    output logic [DATA_WIDTH-1:0] matrix_p13,
    output logic [DATA_WIDTH-1:0] matrix_p21,
    output logic [DATA_WIDTH-1:0] matrix_p22,
    output logic [DATA_WIDTH-1:0] matrix_p23,
    output logic [DATA_WIDTH-1:0] matrix_p31,
    output logic [DATA_WIDTH-1:0] matrix_p32,
    output logic [DATA_WIDTH-1:0] matrix_p33,
    output logic                  matrix_win_valid
);
    localparam int CW = $clog2(IMG_HDISP);
    localparam int RW = $clog2(IMG_VDISP + 1);
    localparam logic [CW-1:0] C_MAX = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0] R_MAX = RW'(IMG_VDISP);
    logic                  acc, href_fall, vsync_rise;
    logic [1:0]            vs_pipe, hs_pipe, ce_pipe;
    logic [CW-1:0]         col_cnt, col1;
    logic [RW-1:0]         row_cnt, row1;
    logic [DATA_WIDTH-1:0] tap1, tap2, y1;
    assign acc                = per_frame_href && per_frame_clken;
    assign href_fall          = hs_pipe[0] && !per_frame_href;
    assign vsync_rise         = per_frame_vsync && !vs_pipe[0];
    assign matrix_frame_vsync = vs_pipe[1];
    assign matrix_frame_href  = hs_pipe[1];
    assign matrix_frame_clken = ce_pipe[1];
    matrix_3x3_generator_line_shift_ram #(
        .RAM_Length (IMG_HDISP),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line_ram (
        .clock   (clock),
        .rst_n   (rst_n),
        .clken   (acc),
        .shiftin (per_img_Y),
        .taps0x  (tap1),
        .taps1x  (tap2)
    );
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe <= '0;
            hs_pipe <= '0;
            ce_pipe <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            col1    <= '0;
            row1    <= '0;
            y1      <= '0;
        end else begin
            vs_pipe <= {vs_pipe[0], per_frame_vsync};
            hs_pipe <= {hs_pipe[0], per_frame_href};
            ce_pipe <= {ce_pipe[0], acc};
            col_cnt <= href_fall ? '0 : (acc && col_cnt != C_MAX) ? col_cnt + CW'(1) : col_cnt;
            row_cnt <= vsync_rise ? '0 : (href_fall && row_cnt != R_MAX) ? row_cnt + RW'(1) : row_cnt;
            col1    <= col_cnt;
            row1    <= row_cnt;
            y1      <= per_img_Y;
        end
    end
    // Out-of-image entries are zeroed as they enter or shift, so zeros persist across the row
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            {matrix_p11, matrix_p12, matrix_p13} <= '0;
            {matrix_p21, matrix_p22, matrix_p23} <= '0;
            {matrix_p31, matrix_p32, matrix_p33} <= '0;
            matrix_win_valid <= 1'b0;
        end else begin
            matrix_win_valid <= ce_pipe[0] && row1 >= RW'(2) && col1 >= CW'(2);
            if (ce_pipe[0]) begin
                matrix_p11 <= (col1 >= CW'(2)) ? matrix_p12 : '0;
                matrix_p12 <= (col1 >= CW'(1)) ? matrix_p13 : '0;
                matrix_p13 <= (row1 >= RW'(2)) ? tap2 : '0;
                matrix_p21 <= (col1 >= CW'(2)) ? matrix_p22 : '0;
                matrix_p22 <= (col1 >= CW'(1)) ? matrix_p23 : '0;
                matrix_p23 <= (row1 >= RW'(1)) ? tap1 : '0;
                matrix_p31 <= (col1 >= CW'(2)) ? matrix_p32 : '0;
                matrix_p32 <= (col1 >= CW'(1)) ? matrix_p33 : '0;
                matrix_p33 <= y1;
            end
        end
    end
endmodule

// File: tb/tb_matrix_3x3_generator.sv
// tb_matrix_3x3_generator: scoreboard bench for the 3x3 window generator on a 4x4 frame
module tb_matrix_3x3_generator;
    localparam int H = 4;
    localparam int V = 4;
    logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [7:0] y = '0;
    logic o_vs, o_hs, o_ce, o_valid;
    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [71:0] obs, last = '0;
    logic [2:0] h1 = '0, h2 = '0;
    typedef struct { logic [71:0] win; logic v; bit cw; } exp_t;
    exp_t q[$];
    int n_chk = 0, n_err = 0;
    bit sb_en = 1'b1;
    matrix_3x3_generator #(.IMG_HDISP(H), .IMG_VDISP(V), .DATA_WIDTH(8)) dut (
        .clock(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_Y(y),
        .matrix_frame_vsync(o_vs), .matrix_frame_href(o_hs), .matrix_frame_clken(o_ce),
        .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
        .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
        .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
        .matrix_win_valid(o_valid)
    );
    always #5 clk = ~clk;
    assign obs = {p11, p12, p13, p21, p22, p23, p31, p32, p33};
    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic logic [71:0] exp_win(input logic [7:0] ofs, input int r, input int c);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int rr, cc;
                rr = r - 2 + i;
                cc = c - 2 + j;
                if (rr >= 0 && cc >= 0) w[71-8*(3*i+j) -: 8] = ofs + 8'(16 * rr + cc);
            end
        return w;
    endfunction
    task automatic cyc(input logic vs, input logic hs, input logic ce, input logic [7:0] d);
        vsync = vs;
        href  = hs;
        clken = ce;
        y     = d;
        @(posedge clk);
        #1;
    endtask
    task automatic frame(input logic [7:0] ofs, input int gap, input int extra_row, input int abort_row);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        for (int r = 0; r < V; r++) begin
            int n;
            n = (r == extra_row) ? H + 2 : H;
            check("row_cnt", 72'(dut.row_cnt), 72'(r));
            for (int k = 0; k < n; k++) begin
                int c;
                exp_t e;
                c = (k < H) ? k : H - 1;
                if (r == abort_row && k == 2) return;
                e.win = exp_win(ofs, r, c);
                e.v   = r >= 2 && c >= 2;
                e.cw  = extra_row < 0 || r < extra_row || (r == extra_row && k < H);
                q.push_back(e);
                cyc(0, 1, 1, ofs + 8'(16 * r + k));
                repeat (gap) cyc(0, 1, 0, 8'hff);
            end
            check("col_sat", 72'(dut.col_cnt), 72'(H - 1));
            cyc(0, 0, 1, 8'hee); cyc(0, 0, 1, 8'hee); cyc(0, 0, 0, 0);
        end
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '0;
            h2 <= '0;
        end else begin
            h1 <= {vsync, href, href && clken};
            h2 <= h1;
        end
    end
    always @(negedge clk) begin
        exp_t e;
        check("ctl_align", 72'({o_vs, o_hs, o_ce}), 72'(h2));
        if (!rst_n) begin
            check("rst_out", {obs[70:0], o_valid}, '0);
            last <= '0;
        end else if (sb_en) begin
            if (o_ce) begin
                if (q.size() == 0) check("sb_underrun", 72'(q.size()), 72'(1));
                else begin
                    e = q.pop_front();
                    if (e.cw) check("window", obs, e.win);
                    check("win_valid", 72'(o_valid), 72'(e.v));
                    last <= e.cw ? e.win : obs;
                end
            end else begin
                check("hold", obs, last);
                check("valid_idle", 72'(o_valid), '0);
            end
        end
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        frame(8'h00, 0, -1, -1);
        repeat (3) cyc(0, 0, 0, 0);
        frame(8'h00, 2, -1, -1);
        frame(8'h00, 0, -1, -1);
        frame(8'h80, 0, -1, -1);
        frame(8'h00, 0, -1, 2);
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        q.delete();
        #1;
        check("rst_now", {obs, o_vs, o_hs, o_ce, o_valid}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        frame(8'h00, 0, -1, -1);
        frame(8'h00, 0, 2, -1);
        repeat (4) cyc(0, 0, 0, 0);
        check("sb_drain", 72'(q.size()), '0);
        sb_en = 1'b0;
        repeat (200) cyc(1'($urandom_range(0, 3) == 0), 1'($urandom % 2), 1'($urandom % 2), 8'($urandom));
        repeat (4) cyc(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/matrix_3x3_generator.md
Name: matrix_3x3_generator

Overview:
- Converts a raster pixel stream into a 3x3 neighbourhood window, one window per accepted pixel, for the downstream filter stages (Sobel, median, erosion/dilation).
- Sits directly after the two-line shift-RAM stage: it drives that stage's input, consumes its two line-delayed taps and assembles the window.
- It also delays the frame control signals so they stay aligned with the window.

Parameters:
- IMG_HDISP, 640, active pixels per line; this is also the line-buffer length.
- IMG_VDISP, 480, active lines per frame; the row counter saturates at this value.
- DATA_WIDTH, 8, pixel width.

Ports:
- clock  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  frame sync, active high.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel enable; a pixel is accepted when href && clken.
- per_img_Y  in  DATA_WIDTH  pixel data.
- matrix_frame_vsync  out  1  vsync delayed 2 clocks.
- matrix_frame_href  out  1  href delayed 2 clocks.
- matrix_frame_clken  out  1  accept strobe delayed 2 clocks.
- matrix_p11..matrix_p33  out  DATA_WIDTH each (9 ports)  window values; row 1 is oldest, column 1 is leftmost.
- matrix_win_valid  out  1  high with matrix_frame_clken when the whole window lies inside the image.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs go to 0; col_cnt, row_cnt and the delay pipes go to 0. Line-buffer RAM contents are not cleared; they are hidden by masking.
- Accept: acc = per_frame_href && per_frame_clken. The line buffer shifts only on acc.
- Column counter col_cnt:
  - +1 per acc, saturating at IMG_HDISP-1.
  - Cleared on the falling edge of href.
- Row counter row_cnt:
  - +1 on each href falling edge, saturating at IMG_VDISP.
  - Cleared on the rising edge of vsync.
  - row_cnt/col_cnt name the pixel being accepted now.
- Pipeline:
  - Stage 1 (t+1): the line buffer presents tap1 = pixel(r-1,c) and tap2 = pixel(r-2,c) (1-clock read). per_img_Y, row_cnt and col_cnt are registered alongside.
  - Stage 2 (t+2), only when stage-1 acc is set: each row shifts left (pX1<=pX2, pX2<=pX3). New column: p13<=tap2, p23<=tap1, p33<=Y.
  - When stage-1 acc is clear, the window holds its value.
- Masking:
  - Any entry whose source row < 0 (row_cnt < 1 or < 2) or source column < 0 (col_cnt < 1 or < 2) is output as 0.
  - Example: pixel(0,0) gives p33=Y and all other entries 0.
  - Masking is applied when the column enters the window, so shifted zeros stay zeros.
- Window valid: matrix_win_valid = delayed acc && row>=2 && col>=2.
- Control alignment: vsync, href and acc each pass through a 2-flop shift register. Latency is exactly 2 clocks regardless of clken density (every cycle, or sparse gaps).
- Boundaries:
  - More than IMG_HDISP pixels in a line: col_cnt saturates, and the line buffer accepts the extra pixels (wrap misalignment is the upstream's fault). No lockup.
  - Vsync rising mid-line: row_cnt resets immediately and masking restarts.
  - Reset mid-frame: outputs are 0 from the first clock after deassertion; the first post-reset line is fully masked in rows 1-2.
  - href low while clken is high: not accepted, and counters do not move.
- Arithmetic: counters use $clog2(IMG_HDISP) and $clog2(IMG_VDISP+1) bits. There is no arithmetic on pixel data.

Decomposition:
- Shared package (img_proc_pkg):
  - IMG_HDISP and IMG_VDISP defaults.
  - DATA_WIDTH.
  - A pixel typedef.
  - A 3x3 window struct typedef for later filter stages; the ports stay flat.
- One sub-module: the existing two-line shift RAM, instantiated with RAM_Length=IMG_HDISP and fed per_img_Y with clken=acc. Its taps0x is tap1 and taps1x is tap2.
- Counters, masking and the window registers stay in this module.

Test Plan:
1. 4x4 frame (IMG_HDISP=4, IMG_VDISP=4), pixel=16*r+c, clken every cycle:
   - At the clock 2 after pixel(2,2) is accepted: p11..p33 = 00,01,02,10,11,12,20,21,22 and matrix_win_valid=1.
   - At pixel(1,0): p23=00, p33=10, all other entries 0, valid=0.
2. Same frame with clken every 3rd cycle: identical window sequence. matrix_frame_clken pulses exactly 2 clocks after each input strobe, and the window holds between strobes.
3. Two back-to-back frames, second frame data = first+0x80: row 0 of frame 2 shows p11..p23 = 0 (no frame-1 leakage), and valid stays 0 until pixel(2,2).
4. rst_n pulsed low for 1 clock mid-line 2: all outputs read 0 immediately. After release, restart with vsync; the first window equals the scenario 1 result.
5. Line with 6 strobes at IMG_HDISP=4: col_cnt holds at 3, there is no X or hang, and the next line's row_cnt is 1 higher.
6. Control alignment: random vsync/href/clken patterns; the matrix_frame_* outputs equal the inputs delayed by exactly 2 clocks on every cycle.
